// File: rtl/gemm_issue_sequencer_pkg.sv
// Shared types and sizes for the GEMM issue sequencer: request kinds,
// FSM states and default matrix/row widths.
package gemm_issue_sequencer_pkg;

  localparam int GEMM_MAT_S_W = 4;
  localparam int GEMM_ROW_S_W = 2;
  localparam int GEMM_ROWS    = 4;

  typedef enum logic [1:0] {
    REQ_INPUT   = 2'b00,
    REQ_PARTIAL = 2'b01,
    REQ_WEIGHT  = 2'b10
  } gemm_req_t;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_DRAIN = 3'd1,
    S_ISSUE_W    = 3'd2,
    S_ISSUE_IP   = 3'd3,
    S_DONE       = 3'd4
  } gemm_seq_state_t;

endpackage

// File: rtl/gemm_issue_sequencer_if.sv
// Instruction-in / row-request-out bundle of the GEMM issue sequencer.
// master = the sequencer, slave = scheduler plus scratchpad side.
interface gemm_issue_sequencer_if
  import gemm_issue_sequencer_pkg::*;
#(
  parameter int MAT_S_W = GEMM_MAT_S_W,
  parameter int ROW_S_W = GEMM_ROW_S_W
);
  // Both channels: a transfer happens on a cycle where valid & ready are high;
  // while valid & !ready the payload is held and valid does not drop.
  logic               instr_valid;
  logic               instr_ready;
  logic [MAT_S_W-1:0] instr_weight_mat;
  logic [MAT_S_W-1:0] instr_input_mat;
  logic [MAT_S_W-1:0] instr_partial_mat;
  logic               instr_has_partial;
  logic               instr_force_weight;

  logic               req_valid;
  logic               req_ready;
  gemm_req_t          req_type;
  logic [MAT_S_W-1:0] req_mat;
  logic [ROW_S_W-1:0] req_row;

  modport master (
    input  instr_valid, instr_weight_mat, instr_input_mat, instr_partial_mat,
           instr_has_partial, instr_force_weight, req_ready,
    output instr_ready, req_valid, req_type, req_mat, req_row
  );

  modport slave (
    output instr_valid, instr_weight_mat, instr_input_mat, instr_partial_mat,
           instr_has_partial, instr_force_weight, req_ready,
    input  instr_ready, req_valid, req_type, req_mat, req_row
  );
endinterface

// File: rtl/gemm_issue_sequencer.sv
// Takes one GEMM tile instruction, issues weight rows (only when the weight
// tile changes, after the array drains) and then input/partial row requests.
module gemm_issue_sequencer
  import gemm_issue_sequencer_pkg::*;
#(
  parameter int ROWS    = GEMM_ROWS,
  parameter int MAT_S_W = GEMM_MAT_S_W,
  parameter int ROW_S_W = GEMM_ROW_S_W
) (
  input  logic                   CLK,
  input  logic                   RST,
  gemm_issue_sequencer_if.master bus,
  input  logic                   drained,
  output logic                   new_weight,
  output logic                   busy,
  output logic                   done,
  output gemm_seq_state_t        dbg_state
);

  gemm_seq_state_t    r_state, w_next;
  logic [ROW_S_W-1:0] r_row_cnt;
  logic               r_phase;
  logic               r_weight_loaded;
  logic [MAT_S_W-1:0] r_loaded_mat;
  logic [MAT_S_W-1:0] r_w_mat, r_i_mat, r_p_mat;
  logic               r_has_partial;
  logic               r_new_weight;

  logic w_issuing, w_accept, w_last_row, w_ip_last, w_reload, w_take_instr;

  assign w_issuing    = (r_state == S_ISSUE_W) || (r_state == S_ISSUE_IP);
  assign w_accept     = w_issuing & bus.req_ready;
  assign w_last_row   = (r_row_cnt == ROW_S_W'(ROWS - 1));
  // Without partials every accept is the last of its row.
  assign w_ip_last    = w_last_row & (r_has_partial ? r_phase : 1'b1);
  assign w_take_instr = (r_state == S_IDLE) & bus.instr_valid;
  assign w_reload     = !r_weight_loaded | bus.instr_force_weight
                      | (bus.instr_weight_mat != r_loaded_mat);

  assign new_weight = r_new_weight;
  assign dbg_state  = r_state;

  always_comb begin
    w_next          = r_state;
    bus.instr_ready = 1'b0;
    bus.req_valid   = 1'b0;
    bus.req_type    = REQ_INPUT;
    bus.req_mat     = r_i_mat;
    bus.req_row     = r_row_cnt;
    busy            = 1'b1;
    done            = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.instr_ready = 1'b1;
        busy            = 1'b0;
        if (bus.instr_valid) w_next = w_reload ? S_WAIT_DRAIN : S_ISSUE_IP;
      end
      S_WAIT_DRAIN: begin
        if (drained) w_next = S_ISSUE_W;
      end
      S_ISSUE_W: begin
        bus.req_valid = 1'b1;
        bus.req_type  = REQ_WEIGHT;
        bus.req_mat   = r_w_mat;
        if (w_accept && w_last_row) w_next = S_ISSUE_IP;
      end
      S_ISSUE_IP: begin
        bus.req_valid = 1'b1;
        if (r_phase) begin
          bus.req_type = REQ_PARTIAL;
          bus.req_mat  = r_p_mat;
        end
        if (w_accept && w_ip_last) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state         <= S_IDLE;
      r_row_cnt       <= '0;
      r_phase         <= 1'b0;
      r_weight_loaded <= 1'b0;
      r_loaded_mat    <= '0;
      r_w_mat         <= '0;
      r_i_mat         <= '0;
      r_p_mat         <= '0;
      r_has_partial   <= 1'b0;
      r_new_weight    <= 1'b0;
    end else begin
      r_state      <= w_next;
      // High exactly during the first ISSUE_W cycle.
      r_new_weight <= (r_state == S_WAIT_DRAIN) && drained;
      if (w_take_instr) begin
        r_w_mat       <= bus.instr_weight_mat;
        r_i_mat       <= bus.instr_input_mat;
        r_p_mat       <= bus.instr_partial_mat;
        r_has_partial <= bus.instr_has_partial;
        r_row_cnt     <= '0;
        r_phase       <= 1'b0;
      end
      if ((r_state == S_WAIT_DRAIN) && drained) r_row_cnt <= '0;
      if ((r_state == S_ISSUE_W) && w_accept) begin
        r_row_cnt <= r_row_cnt + 1'b1;
        if (w_last_row) begin
          r_row_cnt       <= '0;
          r_phase         <= 1'b0;
          r_loaded_mat    <= r_w_mat;
          r_weight_loaded <= 1'b1;
        end
      end
      if ((r_state == S_ISSUE_IP) && w_accept) begin
        if (r_has_partial) begin
          r_phase <= ~r_phase;
          if (r_phase) r_row_cnt <= r_row_cnt + 1'b1;
        end else begin
          r_row_cnt <= r_row_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_gemm_issue_sequencer.sv
// Self-checking bench for gemm_issue_sequencer: directed scenarios plus
// randomized instructions against a request-list model.
module tb_gemm_issue_sequencer;
  import gemm_issue_sequencer_pkg::*;

  localparam int MW = GEMM_MAT_S_W;
  localparam int RW = GEMM_ROW_S_W;
  localparam int R  = GEMM_ROWS;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst;
  logic drained;
  logic new_weight, busy, done;
  gemm_seq_state_t dbg_state;

  gemm_issue_sequencer_if #(.MAT_S_W(MW), .ROW_S_W(RW)) bus();

  gemm_issue_sequencer #(.ROWS(R), .MAT_S_W(MW), .ROW_S_W(RW)) dut (
    .CLK       (clk),
    .RST       (rst),
    .bus       (bus.master),
    .drained   (drained),
    .new_weight(new_weight),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [8:0] exp_q[$];   // {last_of_instr, type, mat, row}
  logic [7:0] log_q[$];   // every transferred {type, mat, row}
  logic       m_loaded = 1'b0;
  logic [MW-1:0] m_mat = '0;
  int   exp_nw_total = 0, nw_seen = 0, xfers = 0;
  int   first_xfer_cyc = -1, nw_cyc = -1, last_done_cyc = -1;
  logic exp_done = 1'b0, prev_valid = 1'b0, prev_stall = 1'b0;
  logic [7:0] prev_fields = '0;
  logic check_en = 1'b0;
  logic rdy_rand = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [8:0] mk(input logic last, input gemm_req_t t,
                                    input logic [MW-1:0] m, input int row);
    return {last, t, m, RW'(row)};
  endfunction

  // ---------------- req_ready driver ----------------
  always @(posedge clk) begin
    #1;
    bus.req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [7:0] f;
    logic [8:0] e;
    f = {bus.req_type, bus.req_mat, bus.req_row};
    if (rst) begin
      prev_valid = 1'b0;
      prev_stall = 1'b0;
      exp_done   = 1'b0;
    end else if (check_en) begin
      chk("done", done, exp_done);
      exp_done = 1'b0;
      if (done) last_done_cyc = cyc;
      chk("new_weight", new_weight,
          bus.req_valid && bus.req_type == REQ_WEIGHT && bus.req_row == '0 && !prev_valid);
      if (new_weight) begin
        nw_seen++;
        nw_cyc = cyc;
      end
      chk("ready_vs_busy", bus.instr_ready, !busy);
      if (prev_stall) begin
        chk("stall_valid", bus.req_valid, 1'b1);
        chk("stall_fields", f, prev_fields);
      end
      if (bus.req_valid && bus.req_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_req: got %0h expected none (cycle %0d)", f, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("req", f, e[7:0]);
          exp_done = e[8];
        end
        log_q.push_back(f);
        xfers++;
        if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
      end
      prev_valid  = bus.req_valid;
      prev_stall  = bus.req_valid && !bus.req_ready;
      prev_fields = f;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the accept edge with
  // instr_valid still high so the caller may hold it or drop it.
  task automatic issue(input logic [MW-1:0] w, i, p, input logic hp, f,
                       output int acc, output logic reload);
    bus.instr_weight_mat   = w;
    bus.instr_input_mat    = i;
    bus.instr_partial_mat  = p;
    bus.instr_has_partial  = hp;
    bus.instr_force_weight = f;
    bus.instr_valid        = 1'b1;
    acc = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (bus.instr_ready) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) chk("accept_timeout", 32'd0, 32'd1);
    reload = !m_loaded || f || (w != m_mat);
    if (reload) begin
      exp_nw_total++;
      for (int r = 0; r < R; r++) exp_q.push_back(mk(1'b0, REQ_WEIGHT, w, r));
      m_loaded = 1'b1;
      m_mat    = w;
    end
    for (int r = 0; r < R; r++) begin
      exp_q.push_back(mk(!hp && r == R - 1, REQ_INPUT, i, r));
      if (hp) exp_q.push_back(mk(r == R - 1, REQ_PARTIAL, p, r));
    end
    sync();
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (done) begin
        dc = cyc;
        break;
      end
    end
    if (dc < 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    sync();
    rst = 1'b1;
    exp_q.delete();
    m_loaded = 1'b0;
    m_mat    = '0;
    sync();
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc, acc_b, dc, x0;
    logic rl;
    rst = 1'b1;
    drained = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr_weight_mat = '0;
    bus.instr_input_mat = '0;
    bus.instr_partial_mat = '0;
    bus.instr_has_partial = 1'b0;
    bus.instr_force_weight = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_en = 1'b1;
    @(negedge clk);
    chk("rst_instr_ready", bus.instr_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_req_valid", bus.req_valid, 1'b0);
    chk("rst_new_weight", new_weight, 1'b0);
    chk("rst_done", done, 1'b0);

    // 1: cold weights, partials present
    sync();
    log_q.delete();
    first_xfer_cyc = -1;
    nw_cyc = -1;
    issue(4'd3, 4'd5, 4'd7, 1'b1, 1'b0, acc, rl);
    bus.instr_valid = 1'b0;
    wait_done(dc);
    chk("t1_done_lat", dc - acc, 14);
    chk("t1_nw_lat", nw_cyc - acc, 2);
    chk("t1_first_req", first_xfer_cyc - acc, 2);
    chk("t1_count", log_q.size(), 12);
    chk("t1_req0", log_q[0], {REQ_WEIGHT, 4'd3, 2'd0});
    chk("t1_req4", log_q[4], {REQ_INPUT, 4'd5, 2'd0});
    chk("t1_req5", log_q[5], {REQ_PARTIAL, 4'd7, 2'd0});
    chk("t1_req11", log_q[11], {REQ_PARTIAL, 4'd7, 2'd3});

    // 2: same weights, no partials
    sync();
    first_xfer_cyc = -1;
    nw_cyc = -1;
    issue(4'd3, 4'd6, 4'd0, 1'b0, 1'b0, acc, rl);
    bus.instr_valid = 1'b0;
    wait_done(dc);
    chk("t2_done_lat", dc - acc, 5);
    chk("t2_first_req", first_xfer_cyc - acc, 1);
    chk("t2_no_nw", nw_cyc, -1);

    // 3: new weights wait for drain, then forced reload of the same ID
    drained = 1'b0;
    sync();
    issue(4'd4, 4'd1, 4'd2, 1'b1, 1'b0, acc, rl);
    bus.instr_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t3_busy", busy, 1'b1);
      chk("t3_no_req", bus.req_valid, 1'b0);
    end
    sync();
    drained = 1'b1;
    wait_done(dc);
    sync();
    nw_cyc = -1;
    issue(4'd4, 4'd1, 4'd2, 1'b0, 1'b1, acc, rl);
    bus.instr_valid = 1'b0;
    wait_done(dc);
    chk("t3_force_nw", nw_cyc - acc, 2);

    // 4: random backpressure on a no-reload instruction
    rdy_rand = 1'b1;
    sync();
    x0 = xfers;
    issue(4'd4, 4'd3, 4'd1, 1'b1, 1'b0, acc, rl);
    bus.instr_valid = 1'b0;
    wait_done(dc);
    chk("t4_xfers", xfers - x0, 8);
    rdy_rand = 1'b0;

    // 5: reset after weight row 1 is accepted
    sync();
    issue(4'd3, 4'd2, 4'd1, 1'b1, 1'b0, acc, rl);
    bus.instr_valid = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.req_valid && bus.req_ready && bus.req_type == REQ_WEIGHT && bus.req_row == 2'd1)
        break;
    end
    do_reset();
    @(negedge clk);
    chk("t5_req_valid", bus.req_valid, 1'b0);
    chk("t5_instr_ready", bus.instr_ready, 1'b1);
    chk("t5_busy", busy, 1'b0);
    sync();
    nw_cyc = -1;
    issue(4'd3, 4'd2, 4'd1, 1'b0, 1'b0, acc, rl);
    bus.instr_valid = 1'b0;
    wait_done(dc);
    chk("t5_reload_nw", nw_cyc - acc, 2);

    // 6: instr_valid held across a busy instruction
    sync();
    issue(4'd3, 4'd4, 4'd5, 1'b0, 1'b0, acc, rl);
    issue(4'd3, 4'd6, 4'd7, 1'b1, 1'b0, acc_b, rl);
    bus.instr_valid = 1'b0;
    chk("t6_accept_after_done", acc_b, last_done_cyc + 1);
    wait_done(dc);
    chk("t6_done_lat", dc - acc_b, 9);

    // random instructions
    for (int n = 0; n < 25; n++) begin
      logic [MW-1:0] w, i, p;
      logic hp, f;
      int dly;
      w = MW'($urandom_range(0, 3));
      i = MW'($urandom_range(0, 15));
      p = MW'($urandom_range(0, 15));
      hp = 1'($urandom_range(0, 1));
      f = ($urandom_range(0, 3) == 0);
      dly = $urandom_range(0, 3);
      rdy_rand = 1'($urandom_range(0, 1));
      drained = (dly == 0);
      sync();
      issue(w, i, p, hp, f, acc, rl);
      bus.instr_valid = 1'b0;
      if (dly > 0) begin
        repeat (dly) @(posedge clk);
        #1 drained = 1'b1;
      end
      wait_done(dc);
      if (!rdy_rand && dly == 0)
        chk("rand_done_lat", dc - acc, R * (hp ? 2 : 1) + (rl ? R + 1 : 0) + 1);
    end
    rdy_rand = 1'b0;
    repeat (3) @(negedge clk);
    chk("exp_q_empty", exp_q.size(), 0);
    chk("nw_total", nw_seen, exp_nw_total);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    failures++;
    $display("FAIL global_timeout: got running expected finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
